// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: one WIDTH+1-bit adder, WIDTH add/shift steps plus a
// finalize step that applies the sign, unsigned or two's-complement per transaction.
module seq_shift_add_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;
  assign accept    = in_valid & in_ready;

  // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is still correct as unsigned.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign prod  = {acc_q, mplier_q};

  // NOTE: every variable is given its hold value first so no path through the case leaves
  // it unassigned; otherwise the combinational block would infer latches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d    = CNT_W'(WIDTH);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          acc_d    = sum[WIDTH:1];
          mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          // Sign fix-up gets its own cycle so the negator stays off the adder path.
          p_d     = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: WIDTH=8 instance for directed/random products, latency, backpressure
// and reset; WIDTH=2 instance for the exhaustive back-to-back unsigned sweep.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst8, in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        rst2, in_valid2, in_ready2, sm2, out_valid2, out_ready2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  seq_shift_add_multiplier #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .signed_mode(sm2), .out_valid(out_valid2),
    .out_ready(out_ready2), .p(p2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiplication, truncated to the 16-bit product.
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int r;
    if (sm) r = $signed(a) * $signed(b);
    else    r = int'(a) * int'(b);
    return r[15:0];
  endfunction

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sm, input int hold);
    logic [15:0] exp;
    int k;
    exp = model8(a, b, sm);
    k = 0;
    while (!in_ready8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready idle", in_ready8, 1);
    a8 = a; b8 = b; sm8 = sm; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    check("busy after accept", busy8, 1);
    k = 1;
    while (!out_valid8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", k - 1, 9);
    check("out_valid", out_valid8, 1);
    check("product", p8, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold p", p8, exp);
      check("hold out_valid", out_valid8, 1);
      check("hold in_ready", in_ready8, 0);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("pop out_valid", out_valid8, 0);
    check("pop in_ready", in_ready8, 1);
  endtask

  initial begin
    logic [3:0] q[$];
    int idx, got, cyc, viol;

    rst8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b0;
    rst2 = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0; sm2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid8, 0);
    check("reset p", p8, 0);
    check("reset busy", busy8, 0);
    check("reset in_ready", in_ready8, 0);
    rst8 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("in_ready after reset", in_ready8, 1);

    run_op8(8'd3,   8'd5,   1'b0, 0);
    run_op8(8'd255, 8'd255, 1'b0, 0);
    run_op8(8'h80,  8'h80,  1'b1, 0);
    run_op8(8'hFD,  8'd5,   1'b1, 5);
    run_op8(8'd0,   8'h80,  1'b1, 0);
    run_op8(8'h7F,  8'h80,  1'b1, 1);
    run_op8(8'h80,  8'h7F,  1'b0, 0);
    run_op8(8'hFF,  8'hFF,  1'b1, 0);

    // Reset three cycles into RUN, with in_valid asserted during reset.
    a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clk);
    check("rst out_valid", out_valid8, 0);
    check("rst p", p8, 0);
    check("rst busy", busy8, 0);
    check("rst in_ready", in_ready8, 0);
    @(negedge clk);
    check("no accept in reset", busy8, 0);
    rst8 = 1'b0; in_valid8 = 1'b0;
    viol = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid8 || busy8 || !in_ready8) viol++;
    end
    check("idle after reset", viol, 0);
    run_op8(8'd12, 8'd11, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // WIDTH=2 sweep with in_valid held high and out_ready always asserted.
    idx = 0; got = 0; cyc = 0;
    while (got < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid2) begin
        if (q.size() > 0) check("w2 product", p2, q.pop_front());
        else check("w2 unexpected out_valid", out_valid2, 0);
        got++;
      end
      if (in_ready2) begin
        if (idx < 16) begin
          a2 = idx[3:2]; b2 = idx[1:0];
          q.push_back(4'(idx[3:2]) * 4'(idx[1:0]));
          in_valid2 = 1'b1;
          idx++;
        end else begin
          in_valid2 = 1'b0;
        end
      end
    end
    check("w2 result count", got, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
